// File: rtl/booth_mult_arbiter_pkg.sv
// Shared types for the Booth multiplier arbiter: FSM state encoding
// and the {mr[0],q-1} step decode constants.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] SUB = 2'b10;
  localparam logic [1:0] ADD = 2'b01;

endpackage

// File: rtl/booth_mult_arbiter_if.sv
// Request/result bus of the shared Booth multiplier.
// master: operand sources + result consumer; slave: the arbiter.
interface booth_mult_arbiter_if #(
  parameter int N    = 4,
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_mr;
  logic [NREQ*N-1:0] req_md;
  logic              res_valid;
  logic              res_ready;
  logic [2*N-1:0]    res_product;
  logic [IDW-1:0]    res_id;

  modport master (
    output req_valid, req_mr, req_md, res_ready,
    input  req_ready, res_valid, res_product, res_id
  );

  modport slave (
    input  req_valid, req_mr, req_md, res_ready,
    output req_ready, res_valid, res_product, res_id
  );

endinterface

// File: rtl/booth_mult_core.sv
// Sequential radix-2 Booth multiplier, one step per cycle for N cycles.
// Ports: clk, rst, start (load mr/md), done (pulse on last step), product.
module booth_mult_core
  import booth_pkg::*;
#(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   mr,
  input  logic [N-1:0]   md,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int CW = $clog2(N + 1);

  logic [N:0]    acc;
  logic [N:0]    md_r;
  logic [N:0]    sum;
  logic [N:0]    acc_n;
  logic [N-1:0]  mr_r;
  logic [N-1:0]  mr_n;
  logic          q1;
  logic [CW-1:0] count;

  always_comb begin
    sum = acc;
    unique case ({mr_r[0], q1})
      SUB:     sum = acc - md_r;
      ADD:     sum = acc + md_r;
      default: sum = acc;
    endcase
    acc_n = {sum[N], sum[N:1]};
    mr_n  = {sum[0], mr_r[N-1:1]};
  end

  // product is the post-step value, so it is final while done is high
  assign product = {acc_n[N-1:0], mr_n};
  assign done    = (count == CW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      md_r  <= '0;
      mr_r  <= '0;
      q1    <= 1'b0;
      count <= '0;
    end else if (start) begin
      acc   <= '0;
      md_r  <= {md[N-1], md};
      mr_r  <= mr;
      q1    <= 1'b0;
      count <= CW'(N);
    end else if (count != '0) begin
      acc   <= acc_n;
      mr_r  <= mr_n;
      q1    <= mr_r[0];
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/booth_mult_arbiter.sv
// Round-robin arbiter sharing one Booth multiplier among NREQ sources.
// Ports: clk, rst, bus (slave: requests in, tagged product out), busy.
module booth_mult_arbiter
  import booth_pkg::*;
#(
  parameter int N    = 4,
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  booth_mult_arbiter_if.slave  bus,
  output logic                 busy
);

  state_t         state;
  state_t         state_n;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] gnt;
  logic [IDW-1:0] cand;
  logic [IDW-1:0] id_q;
  logic           found;
  logic           start;
  logic           core_done;
  logic [N-1:0]   sel_mr;
  logic [N-1:0]   sel_md;
  logic [2*N-1:0] prod;
  logic [2*N-1:0] prod_q;

  // first valid index at or after rr_ptr, wrapping
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IDW'((int'(rr_ptr) + k) % NREQ);
      if (!found && bus.req_valid[cand]) begin
        found = 1'b1;
        gnt   = cand;
      end
    end
  end

  assign start = (state == IDLE) && found;

  always_comb begin
    sel_mr        = '0;
    sel_md        = '0;
    bus.req_ready = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (gnt == IDW'(k)) begin
        sel_mr           = bus.req_mr[k*N +: N];
        sel_md           = bus.req_md[k*N +: N];
        bus.req_ready[k] = start;
      end
    end
  end

  booth_mult_core #(.N(N)) u_core (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .mr      (sel_mr),
    .md      (sel_md),
    .done    (core_done),
    .product (prod)
  );

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (found) state_n = RUN;
      RUN:     if (core_done) state_n = DONE;
      DONE:    if (bus.res_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      rr_ptr <= '0;
      id_q   <= '0;
      prod_q <= '0;
    end else begin
      state <= state_n;
      if (start) begin
        id_q <= gnt;
        if (int'(gnt) == NREQ - 1) rr_ptr <= '0;
        else rr_ptr <= gnt + 1'b1;
      end
      if (state == RUN && core_done) prod_q <= prod;
    end
  end

  assign bus.res_valid   = (state == DONE);
  assign bus.res_product = prod_q;
  assign bus.res_id      = id_q;
  assign busy            = (state != IDLE);

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Directed bench for booth_mult_arbiter (N=4, NREQ=4).
// Inputs driven on the falling edge, outputs sampled #1 later.
module tb_booth_mult_arbiter;

  logic clk;
  logic rst;
  logic busy;
  int   checks;
  int   errors;

  booth_mult_arbiter_if #(.N(4), .NREQ(4)) bus ();

  booth_mult_arbiter #(.N(4), .NREQ(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int i, input logic [3:0] mr,
                       input logic [3:0] md);
    bus.req_mr[i*4 +: 4] = mr;
    bus.req_md[i*4 +: 4] = md;
    bus.req_valid[i]     = 1'b1;
  endtask

  // Call at the grant cycle; drops the masked valids after the
  // accept edge, then waits (bounded) for res_valid.
  task automatic wait_res(input logic [3:0] drop, output int lat);
    @(negedge clk);
    bus.req_valid = bus.req_valid & ~drop;
    #1;
    lat = 1;
    while (!bus.res_valid && lat < 20) begin
      @(negedge clk);
      #1;
      lat++;
    end
    if (!bus.res_valid) begin
      checks++;
      errors++;
      $error("FAIL res_timeout observed 0 expected 1");
    end
  endtask

  int lat;
  int hi_cnt;
  int n;
  int g_id [5];
  int g_t  [5];

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_mr = '0;
    bus.req_md = '0;
    bus.res_ready = 1'b1;

    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_res_valid", 32'(bus.res_valid), 0);
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_product", 32'(bus.res_product), 0);
    chk("rst_id", 32'(bus.res_id), 0);
    @(negedge clk);
    rst = 1'b0;

    // req1: 3 * -2
    @(negedge clk);
    drive(1, 4'd3, 4'hE);
    #1 chk("r1_ready", 32'(bus.req_ready), 32'h2);
    wait_res(4'b0010, lat);
    chk("r1_latency", 32'(lat), 5);
    chk("r1_product", 32'(bus.res_product), 32'hFA);
    chk("r1_id", 32'(bus.res_id), 1);

    // req0: -8 * -8, wraps from rr_ptr=2
    @(negedge clk);
    drive(0, 4'h8, 4'h8);
    #1 chk("m88_ready", 32'(bus.req_ready), 32'h1);
    wait_res(4'b0001, lat);
    chk("m88_product", 32'(bus.res_product), 32'h40);
    chk("m88_id", 32'(bus.res_id), 0);

    // 7 * 7
    @(negedge clk);
    drive(0, 4'd7, 4'd7);
    wait_res(4'b0001, lat);
    chk("p77_product", 32'(bus.res_product), 32'h31);

    // 0 * -5
    @(negedge clk);
    drive(0, 4'd0, 4'hB);
    wait_res(4'b0001, lat);
    chk("z5_product", 32'(bus.res_product), 32'h00);
    chk("z5_latency", 32'(lat), 5);

    // reset, then 0 and 2 both pending
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    drive(0, 4'd2, 4'd3);
    drive(2, 4'hF, 4'd5);
    #1 chk("pair_first", 32'(bus.req_ready), 32'h1);
    @(negedge clk);
    bus.req_valid[0] = 1'b0;
    #1 chk("pair_run_ready", 32'(bus.req_ready), 0);
    chk("pair_run_busy", 32'(busy), 1);
    lat = 1;
    while (!bus.res_valid && lat < 20) begin
      @(negedge clk);
      #1;
      lat++;
    end
    chk("pair_a_product", 32'(bus.res_product), 32'h06);
    chk("pair_a_id", 32'(bus.res_id), 0);
    @(negedge clk);
    #1 chk("pair_second", 32'(bus.req_ready), 32'h4);
    wait_res(4'b0100, lat);
    chk("pair_b_product", 32'(bus.res_product), 32'hFB);
    chk("pair_b_id", 32'(bus.res_id), 2);

    // rr_ptr=3: with 0 and 1 pending, 0 wins by wrap
    @(negedge clk);
    drive(0, 4'd1, 4'd1);
    drive(1, 4'd1, 4'd2);
    #1 chk("wrap_grant", 32'(bus.req_ready), 32'h1);
    wait_res(4'b0011, lat);
    chk("wrap_id", 32'(bus.res_id), 0);

    // backpressure: DONE held 6 cycles with req3 pending
    @(negedge clk);
    bus.res_ready = 1'b0;
    drive(1, 4'hD, 4'd5);
    drive(3, 4'd2, 4'd2);
    #1 chk("bp_grant", 32'(bus.req_ready), 32'h2);
    wait_res(4'b0010, lat);
    chk("bp_product", 32'(bus.res_product), 32'hF1);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      chk("bp_valid", 32'(bus.res_valid), 1);
      chk("bp_hold_product", 32'(bus.res_product), 32'hF1);
      chk("bp_hold_id", 32'(bus.res_id), 1);
      chk("bp_no_grant", 32'(bus.req_ready), 0);
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    #1 chk("bp_next_grant", 32'(bus.req_ready), 32'h8);
    wait_res(4'b1000, lat);
    chk("bp_next_product", 32'(bus.res_product), 32'h04);
    chk("bp_next_id", 32'(bus.res_id), 3);

    // all four continuously valid
    @(negedge clk);
    drive(0, 4'd1, 4'd3);
    drive(1, 4'd2, 4'd3);
    drive(2, 4'd3, 4'd3);
    drive(3, 4'd4, 4'd3);
    n = 0;
    for (int t = 0; t < 60; t++) begin
      if (t > 0) @(negedge clk);
      #1;
      if (bus.req_ready != 0 && n < 5) begin
        g_id[n] = 0;
        for (int j = 0; j < 4; j++)
          if (bus.req_ready[j]) g_id[n] = j;
        g_t[n] = t;
        n++;
      end
      if (n == 5) break;
    end
    wait_res(4'b1111, lat);
    chk("rr_count", 32'(n), 5);
    chk("rr_g0", 32'(g_id[0]), 0);
    chk("rr_g1", 32'(g_id[1]), 1);
    chk("rr_g2", 32'(g_id[2]), 2);
    chk("rr_g3", 32'(g_id[3]), 3);
    chk("rr_g4", 32'(g_id[4]), 0);
    for (int k = 0; k < 4; k++)
      chk("rr_interval", 32'(g_t[k+1] - g_t[k]), 6);
    chk("rr_last_product", 32'(bus.res_product), 32'h03);

    // reset on the 2nd RUN cycle aborts the product
    @(negedge clk);
    drive(2, 4'd5, 4'd3);
    #1 chk("abort_grant", 32'(bus.req_ready), 32'h4);
    @(negedge clk);
    bus.req_valid[2] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_valid", 32'(bus.res_valid), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_product", 32'(bus.res_product), 0);
    chk("abort_id", 32'(bus.res_id), 0);
    @(negedge clk);
    rst = 1'b0;
    hi_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      #1;
      if (bus.res_valid || busy) hi_cnt++;
    end
    chk("abort_silent", 32'(hi_cnt), 0);
    @(negedge clk);
    drive(1, 4'hC, 4'd3);
    drive(3, 4'd1, 4'd1);
    #1 chk("abort_rr_ptr", 32'(bus.req_ready), 32'h2);
    wait_res(4'b1010, lat);
    chk("post_product", 32'(bus.res_product), 32'hF4);
    chk("post_id", 32'(bus.res_id), 1);
    chk("post_latency", 32'(lat), 5);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
